// File: rtl/pipelined_add_sub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per RUN cycle with a rippled carry.
// Define SATURATE_EN to clamp Sum to the signed limit when V is set.
module pipelined_add_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Co,
  output logic             V
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
  logic             c_q, co_q, v_q;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] acc_d, sum_d;
  logic             co_d, v_d, c_into_msb;

  // Select the active slice, add it, and splice the result into the partial sum.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
    chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};
    acc_d = acc_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) acc_d[k*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
    end
    // Only meaningful on the last slice, which holds the MSB.
    c_into_msb = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ acc_d[WIDTH-1];
    co_d       = chunk_res[CHUNK];
    v_d        = c_into_msb ^ co_d;
`ifdef SATURATE_EN
    sum_d = v_d ? {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}} : acc_d;
`else
    sum_d = acc_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FIN: begin
          if (Start) begin
            a_q     <= A;
            b_q     <= Sub ? ~B : B;
            c_q     <= Sub ? ~Cin : Cin;
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          c_q   <= chunk_res[CHUNK];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= sum_d;
            co_q    <= co_d;
            v_q     <= v_d;
            state_q <= FIN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy = (state_q == RUN);
  assign Done = (state_q == FIN);
  assign Sum  = sum_q;
  assign Co   = co_q;
  assign V    = v_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub (WIDTH=16, CHUNK=4): results, latency, ignored/overlapped Start, reset abort.
module tb_pipelined_add_sub;

  logic        clk = 1'b0;
  logic        rst, Start, Cin, Sub;
  logic [15:0] A, B;
  logic        Busy, Done, Co, V;
  logic [15:0] Sum;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [15:0] prev_sum = 16'h0000;

`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  pipelined_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .Busy(Busy), .Done(Done), .Sum(Sum), .Co(Co), .V(V)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    A   = 16'($urandom);
    B   = 16'($urandom);
    Cin = 1'($urandom);
    Sub = 1'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        input logic [15:0] es, input logic eco, input logic ev);
    int busy_n;
    bit seen;
    Start = 1'b1; A = a; B = b; Cin = cin; Sub = sub;
    tick();
    Start = 1'b0;
    scramble();
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Done) begin
        seen = 1'b1;
        break;
      end
      if (Busy) begin
        busy_n++;
        check({tag, ".hold"}, 32'(Sum), 32'(prev_sum));
      end
      tick();
    end
    check({tag, ".done"}, 32'(seen), 32'd1);
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'd4);
    check({tag, ".sum"}, 32'(Sum), 32'(es));
    check({tag, ".co"}, 32'(Co), 32'(eco));
    check({tag, ".v"}, 32'(V), 32'(ev));
    check({tag, ".busy_fin"}, 32'(Busy), 32'd0);
    tick();
    check({tag, ".done_1cyc"}, 32'(Done), 32'd0);
    prev_sum = es;
  endtask

  initial begin
    int done_n;
    logic [15:0] got_sum;
    logic got_co, got_v;

    rst = 1'b1; Start = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    tick();
    tick();
    check("rst.busy", 32'(Busy), 32'd0);
    check("rst.done", 32'(Done), 32'd0);
    check("rst.sum", 32'(Sum), 32'd0);
    check("rst.co", 32'(Co), 32'd0);
    check("rst.v", 32'(V), 32'd0);
    rst = 1'b0;
    tick();

    run_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
    run_op("add_cin", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_bin", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1);

    // Abort in the second RUN cycle; previous outputs are all non-zero.
    Start = 1'b1; A = 16'h1111; B = 16'h1111; Cin = 1'b0; Sub = 1'b0;
    tick();
    Start = 1'b0;
    check("abort.busy1", 32'(Busy), 32'd1);
    tick();
    check("abort.busy2", 32'(Busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.busy", 32'(Busy), 32'd0);
    check("abort.done", 32'(Done), 32'd0);
    check("abort.sum", 32'(Sum), 32'd0);
    check("abort.co", 32'(Co), 32'd0);
    check("abort.v", 32'(V), 32'd0);
    done_n = 0;
    for (int i = 0; i < 10; i++) begin
      if (Done) done_n++;
      tick();
    end
    check("abort.no_done", 32'(done_n), 32'd0);
    prev_sum = 16'h0000;

    // Start during RUN must be ignored.
    Start = 1'b1; A = 16'h1000; B = 16'h0234; Cin = 1'b0; Sub = 1'b0;
    tick();
    Start = 1'b0;
    tick();
    check("ign.busy", 32'(Busy), 32'd1);
    Start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; Sub = 1'b1;
    tick();
    Start = 1'b0;
    done_n = 0; got_sum = '0; got_co = 1'b1; got_v = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (Done) begin
        done_n++;
        got_sum = Sum; got_co = Co; got_v = V;
      end
      tick();
    end
    check("ign.done_count", 32'(done_n), 32'd1);
    check("ign.sum", 32'(got_sum), 32'h1234);
    check("ign.co", 32'(got_co), 32'd0);
    check("ign.v", 32'(got_v), 32'd0);
    check("ign.idle", 32'(Busy), 32'd0);
    prev_sum = 16'h1234;

    // Back-to-back: Start held during FIN.
    Start = 1'b1; A = 16'h00FF; B = 16'h0001; Cin = 1'b0; Sub = 1'b0;
    tick();
    Start = 1'b0;
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      if (Done) begin
        done_n = 1;
        break;
      end
      tick();
    end
    check("b2b.first_done", 32'(done_n), 32'd1);
    check("b2b.first_sum", 32'(Sum), 32'h0100);
    Start = 1'b1; A = 16'h0001; B = 16'h0002; Cin = 1'b0; Sub = 1'b0;
    tick();
    Start = 1'b0;
    scramble();
    check("b2b.busy_next", 32'(Busy), 32'd1);
    check("b2b.done_next", 32'(Done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("b2b.hold", 32'(Sum), 32'h0100);
      tick();
      check("b2b.busy_run", 32'(Busy), 32'd1);
    end
    tick();
    check("b2b.second_done", 32'(Done), 32'd1);
    check("b2b.second_sum", 32'(Sum), 32'h0003);
    check("b2b.second_busy", 32'(Busy), 32'd0);
    tick();
    check("b2b.second_done_1cyc", 32'(Done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
